// File: rtl/alu4_arbiter_if.sv
// Bundle of the two requester handshakes, the response handshake and the status outputs
// of alu4_arbiter. The slave side is the arbiter; the master side is whoever drives requests.
interface alu4_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  logic [3:0]       req0_i3;
  logic [1:0]       req0_op;
  logic             req0_add_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  logic [3:0]       req1_i3;
  logic [1:0]       req1_op;
  logic             req1_add_sub;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [3:0]       rsp_f;
  logic             rsp_zero;
  logic             rsp_overflow;

  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_i3, req0_op, req0_add_sub,
    input  req1_valid, req1_a, req1_b, req1_i3, req1_op, req1_add_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_overflow,
    output busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_i3, req0_op, req0_add_sub,
    output req1_valid, req1_a, req1_b, req1_i3, req1_op, req1_add_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_overflow,
    input  busy, op_count
  );
endinterface

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one alu4 between two requesters, one operation in flight.
// alu4 ops: 00 = a +/- b, 01 = a +/- i3, 10 = a & b, 11 = a ^ b (overflow only for +/-).
module alu4_arbiter #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu4_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q;
  logic             id_q;
  logic [3:0]       a_q, b_q, i3_q;
  logic [1:0]       op_q;
  logic             sub_q;
  logic [3:0]       f_q;
  logic             zero_q;
  logic             ovf_q;
  logic [CNT_W-1:0] count_q;

  logic             grant0, grant1;
  logic             take, done;
  logic [3:0]       alu_y, alu_y_x, alu_low, alu_f;
  logic [4:0]       alu_sum;
  logic             alu_ovf;

  assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || prio_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    take    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          take    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so no requester sees an acceptance while reset is held.
  assign bus.req0_ready   = rst_n && (state_q == IDLE) && grant0;
  assign bus.req1_ready   = rst_n && (state_q == IDLE) && grant1;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_f        = f_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.op_count     = count_q;

  // Embedded alu4, fed only from the operand registers; subtract is a + ~y + 1.
  always_comb begin
    alu_y   = (op_q == 2'b01) ? i3_q : b_q;
    alu_y_x = alu_y ^ {4{sub_q}};
    alu_sum = {1'b0, a_q} + {1'b0, alu_y_x} + {4'b0000, sub_q};
    alu_low = {1'b0, a_q[2:0]} + {1'b0, alu_y_x[2:0]} + {3'b000, sub_q};
    alu_f   = alu_sum[3:0];
    alu_ovf = alu_sum[4] ^ alu_low[3];
    case (op_q)
      2'b10: begin
        alu_f   = a_q & b_q;
        alu_ovf = 1'b0;
      end
      2'b11: begin
        alu_f   = a_q ^ b_q;
        alu_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      i3_q    <= '0;
      op_q    <= '0;
      sub_q   <= 1'b0;
      f_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (take) begin
        id_q  <= grant1;
        a_q   <= grant1 ? bus.req1_a       : bus.req0_a;
        b_q   <= grant1 ? bus.req1_b       : bus.req0_b;
        i3_q  <= grant1 ? bus.req1_i3      : bus.req0_i3;
        op_q  <= grant1 ? bus.req1_op      : bus.req0_op;
        sub_q <= grant1 ? bus.req1_add_sub : bus.req0_add_sub;
      end
      if (state_q == EXEC) begin
        f_q    <= alu_f;
        zero_q <= ~|alu_f;
        ovf_q  <= alu_ovf;
      end
      if (done) begin
        count_q <= count_q + CNT_W'(1);
        prio_q  <= ~id_q;
      end
    end
  end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Randomised scoreboard bench for alu4_arbiter: the driver pushes expected results on
// acceptance, an independent monitor pops and compares on each response handshake.
module tb_alu4_arbiter;

  localparam bit RR_INIT = 1'b0;
  localparam int CNT_W   = 2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] i3;
    logic [1:0] op;
    logic       sub;
  } op_t;

  typedef struct packed {
    logic       id;
    logic [3:0] f;
    logic       zero;
    logic       ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu4_arbiter_if #(.CNT_W(CNT_W)) bus ();

  alu4_arbiter #(.RR_INIT(RR_INIT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  op_t  cur[2];
  logic vld[2];
  logic rdy_out;
  bit   in_flight;
  int   since;
  bit   prio_m;
  int   n_acc;
  int   done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference alu4: signed integer arithmetic, overflow when the result leaves -8..7.
  function automatic rsp_t ref_alu(input logic id, input op_t o);
    rsp_t e;
    int   x, y, r;
    e.id  = id;
    e.ovf = 1'b0;
    x = int'($signed(o.a));
    y = int'($signed((o.op == 2'b01) ? o.i3 : o.b));
    case (o.op)
      2'b00, 2'b01: begin
        r     = o.sub ? (x - y) : (x + y);
        e.f   = r[3:0];
        e.ovf = (r > 7) || (r < -8);
      end
      2'b10:   e.f = o.a & o.b;
      default: e.f = o.a ^ o.b;
    endcase
    e.zero = (e.f == 4'd0);
    return e;
  endfunction

  task automatic drive();
    bus.req0_valid   = vld[0];
    bus.req0_a       = cur[0].a;
    bus.req0_b       = cur[0].b;
    bus.req0_i3      = cur[0].i3;
    bus.req0_op      = cur[0].op;
    bus.req0_add_sub = cur[0].sub;
    bus.req1_valid   = vld[1];
    bus.req1_a       = cur[1].a;
    bus.req1_b       = cur[1].b;
    bus.req1_i3      = cur[1].i3;
    bus.req1_op      = cur[1].op;
    bus.req1_add_sub = cur[1].sub;
    bus.rsp_ready    = rdy_out;
  endtask

  task automatic randomize_ops();
    logic [31:0] r;
    for (int i = 0; i < 2; i++) begin
      r      = $urandom;
      cur[i] = r[14:0];
    end
  endtask

  // One clock: check handshake outputs at negedge, update the model, step to posedge+1.
  task automatic cycle();
    logic e0, e1, id;
    @(negedge clk);
    if (in_flight) since++;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!in_flight) begin
      if (vld[0] && vld[1]) begin
        e0 = !prio_m;
        e1 = prio_m;
      end else begin
        e0 = vld[0];
        e1 = vld[1];
      end
    end
    check("req0_ready", bus.req0_ready, e0);
    check("req1_ready", bus.req1_ready, e1);
    check("busy", bus.busy, in_flight);
    check("rsp_valid", bus.rsp_valid, in_flight && since >= 2);
    if (in_flight) begin
      if (since >= 2 && rdy_out) in_flight = 1'b0;
    end else if (e0 || e1) begin
      id = e1;
      sb.push_back(ref_alu(id, cur[id]));
      prio_m    = !id;
      in_flight = 1'b1;
      since     = 0;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld[0]  = 1'b0;
    vld[1]  = 1'b0;
    rdy_out = 1'b1;
    drive();
    for (int k = 0; k < 20 && in_flight; k++) cycle();
    check("drain", in_flight, 1'b0);
    cycle();
  endtask

  task automatic check_count();
    check("op_count", bus.op_count, done % (1 << CNT_W));
  endtask

  task automatic check_all_zero();
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_rsp_f", bus.rsp_f, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    check("rst_rsp_overflow", bus.rsp_overflow, 0);
  endtask

  task automatic single(input int port, input logic [3:0] a, input logic [3:0] b, input logic sub);
    cur[port] = '{a: a, b: b, i3: 4'd0, op: 2'b00, sub: sub};
    vld[port] = 1'b1;
    rdy_out   = 1'b1;
    drive();
    cycle();
    drain();
  endtask

  // Response monitor: pops the scoreboard on every handshake, checks hold under backpressure.
  rsp_t held;
  bit   held_v = 1'b0;
  always @(negedge clk) begin
    rsp_t got, exp;
    if (!rst_n) begin
      sb.delete();
      done   = 0;
      held_v = 1'b0;
    end else begin
      got = '{id: bus.rsp_id, f: bus.rsp_f, zero: bus.rsp_zero, ovf: bus.rsp_overflow};
      if (held_v && bus.rsp_valid) check("rsp_stable", got, held);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp = sb.pop_front();
          check("rsp_id", got.id, exp.id);
          check("rsp_f", got.f, exp.f);
          check("rsp_zero", got.zero, exp.zero);
          check("rsp_overflow", got.ovf, exp.ovf);
          check("op_count_pre", bus.op_count, done % (1 << CNT_W));
        end
        done++;
        held_v = 1'b0;
      end else if (bus.rsp_valid) begin
        held   = got;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    vld[0]    = 1'b0;
    vld[1]    = 1'b0;
    cur[0]    = '0;
    cur[1]    = '0;
    rdy_out   = 1'b1;
    in_flight = 1'b0;
    since     = 0;
    prio_m    = RR_INIT;
    n_acc     = 0;
    drive();
    #12;
    check_all_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: 3+4, 5-5 on port 1, 7+1 overflow.
    single(0, 4'd3, 4'd4, 1'b0);
    check_count();
    single(1, 4'd5, 4'd5, 1'b1);
    single(0, 4'd7, 4'd1, 1'b0);
    check_count();

    // Both requesters valid continuously: grants must alternate.
    start   = n_acc;
    vld[0]  = 1'b1;
    vld[1]  = 1'b1;
    rdy_out = 1'b1;
    for (int k = 0; k < 40 && (n_acc - start) < 4; k++) begin
      randomize_ops();
      drive();
      cycle();
    end
    check("rr_ops", n_acc - start, 4);
    drain();
    check_count();

    // Backpressure: hold the response for several cycles with both requesters pending.
    randomize_ops();
    vld[0]  = 1'b1;
    vld[1]  = 1'b0;
    rdy_out = 1'b0;
    drive();
    cycle();
    vld[0] = 1'b0;
    drive();
    cycle();
    cycle();
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    drive();
    repeat (5) cycle();
    rdy_out = 1'b1;
    drive();
    cycle();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    drive();
    cycle();
    check_count();

    // Reset while the operation is in EXEC: discarded, then first grant follows RR_INIT.
    randomize_ops();
    vld[0] = 1'b1;
    drive();
    cycle();
    rst_n  = 1'b0;
    vld[1] = 1'b1;
    drive();
    #1;
    check_all_zero();
    in_flight = 1'b0;
    since     = 0;
    prio_m    = RR_INIT;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    drain();
    check_count();

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      randomize_ops();
      vld[0]  = ($urandom_range(0, 9) < 6);
      vld[1]  = ($urandom_range(0, 9) < 6);
      rdy_out = ($urandom_range(0, 3) != 0);
      drive();
      cycle();
    end
    drain();
    check("sb_empty", sb.size(), 0);
    check_count();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu4_arbiter.md
Name: alu4_arbiter

Overview:
- Shares one alu4 datapath instance between two requesters (port 0, port 1).
- Each requester presents a complete ALU operation (a, b, i3, op, add_sub) under a valid/ready handshake.
- The block grants round-robin, registers the operands into the embedded alu4, captures f/zero/overflow, and returns them tagged with the requester id under a second valid/ready handshake.
- Sits between the control/sequencing logic and the shared 4-bit ALU; one operation is in flight at a time.

Parameters:
- RR_INIT, 0, requester holding priority after reset (0 or 1).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  4  operand a
- req0_b  input  4  operand b
- req0_i3  input  4  auxiliary operand i3
- req0_op  input  2  ALU op select
- req0_add_sub  input  1  0 = add, 1 = subtract
- req1_valid, req1_ready, req1_a, req1_b, req1_i3, req1_op, req1_add_sub: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_f  output  4  ALU result f
- rsp_zero  output  1  ALU zero flag
- rsp_overflow  output  1  ALU overflow flag
- busy  output  1  state is not IDLE
- op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; prio = RR_INIT.
  - All operand registers, rsp_f, rsp_id, rsp_zero, rsp_overflow, op_count = 0.
  - rsp_valid = 0, busy = 0, req0_ready = req1_ready = 0.
- States: IDLE, EXEC, RESP (2-bit encoding).
- IDLE:
  - reqX_ready is combinational: asserted only for the granted requester, and only in IDLE.
  - Grant rules:
    - only one valid: grant it;
    - both valid: grant prio;
    - none valid: stay in IDLE.
  - On grant: latch the granted port's a, b, i3, op, add_sub and its id; go to EXEC.
- EXEC (exactly 1 cycle):
  - The embedded alu4 is driven from the operand registers only; requester inputs never reach the ALU directly.
  - At the end of the cycle, capture f, zero and overflow into the rsp registers and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_valid && rsp_ready.
  - On handshake:
    - op_count increments (wraps);
    - prio becomes the complement of the served id;
    - return to IDLE.
  - rsp_ready low holds RESP indefinitely; no new grant is made meanwhile (both req_ready stay 0).
- Latency:
  - Accept in cycle N, rsp_valid in cycle N+2.
  - With rsp_ready held high, the minimum issue interval per operation is 3 cycles.
- Fairness:
  - prio updates only on response handshake.
  - When both requesters stay valid, grants strictly alternate.
  - A lone requester may be served back to back.
- Requester inputs may change freely while its ready is low; they are sampled only in the grant cycle.
- Arithmetic: results are exactly those of the alu4 datapath (4-bit wrap; overflow = carry-into-MSB XOR carry-out; zero = NOR of f). The block adds no width extension.
- busy = (state != IDLE).
- Reset asserted in EXEC or RESP:
  - the in-flight operation is discarded and no response is produced;
  - after rst_n rises, the first grant follows RR_INIT.
- A valid dropped before ready is not a protocol error; nothing is latched.

Test Plan:
- Reset, then req0 only: a=3, b=4, op=add, add_sub=0 -> req0_ready in cycle 0, rsp_valid in cycle 2, rsp_id=0, f=7, zero=0, overflow=0, op_count=1.
- req1 only: a=5, b=5, subtract -> f=0, zero=1, overflow=0, rsp_id=1.
- Overflow case: a=7, b=1, add -> f=8, overflow=1, zero=0.
- Both valid continuously, RR_INIT=0, 4 ops -> grants 0,1,0,1; rsp_id sequence matches; op_count=4.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready both 0, busy=1; release -> handshake, IDLE next cycle.
- Reset pulse during EXEC -> all outputs 0 immediately, no rsp_valid afterwards; a subsequent simultaneous request is granted to RR_INIT.
- Wrap: CNT_W=2, 5 completed ops -> op_count=1.
